debug_mem_arbiter: RTL
======================

Name: debug_mem_arbiter

Overview:
- Shares the MCU's single-port memory between two requesters: the CPU datapath and the debug controller (debugger memory read/write commands).
- The CPU has priority. The debugger is served in idle cycles, or forcibly after a bounded starvation time.
- Tracks ownership of in-flight reads through a tag pipeline, so read data returns to the correct requester.
- Sits between the MCU core, the debug controller FSM and the memory module.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles (1..4)
- STARVE_MAX, 15, cycles a pending debugger request may be refused before it preempts the CPU (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write enable
- cpu_byte  in  1  CPU byte-granularity access
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU access refused this cycle; CPU must hold its request
- cpu_rdata  out  DATA_W  CPU read data, RD_LAT cycles after issue
- mcu_paused  in  1  MCU paused; debugger always wins
- dbg_req  in  1  debugger request, level, held until dbg_ack
- dbg_we  in  1  debugger write enable
- dbg_byte  in  1  debugger byte access
- dbg_addr  in  ADDR_W  debugger address
- dbg_wdata  in  DATA_W  debugger write data
- dbg_busy  out  1  debugger op accepted, not yet acknowledged
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered debugger read data, held until next debugger read completes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_byte  out  1  memory byte access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_cnt  out  16  CPU stall-cycle count (optional feature)

Behaviour:
- Reset values:
  - cpu_stall, dbg_busy, dbg_ack, mem_en, mem_we, mem_byte = 0.
  - dbg_rdata, stall_cnt = 0.
  - starve counter = 0, tag pipeline cleared, state S_IDLE.
- States:
  - S_IDLE: no debugger op outstanding.
  - S_DBG_RD: debugger read issued, waiting RD_LAT cycles.
  - S_DBG_ACK: drives the dbg_ack pulse.
- Issue decision is combinational, in S_IDLE with dbg_req=1. The debugger is granted if any of the following hold:
  - cpu_req=0
  - mcu_paused=1
  - starve counter == STARVE_MAX
- Otherwise the CPU is granted.
- Debugger grant cycle:
  - mem_* driven from the dbg_* inputs; those inputs are sampled only in this cycle.
  - cpu_stall = cpu_req.
  - dbg_busy rises next cycle.
- Starve counter:
  - Increments, saturating at STARVE_MAX, each cycle dbg_req=1 in S_IDLE without a grant.
  - Clears on a debugger grant.
- CPU path:
  - mem_* driven from the cpu_* inputs whenever the CPU is granted; mem_en = cpu_req.
  - cpu_stall=0 in those cycles.
  - The CPU may issue during S_DBG_RD and S_DBG_ACK; the memory is pipelined.
- Tag pipeline:
  - RD_LAT-deep shift register of {valid, owner}, loaded on every read issue (mem_en & !mem_we).
  - At the pipeline output: if owner=CPU, mem_rdata is forwarded combinationally to cpu_rdata; if owner=DBG, dbg_rdata is registered.
- Debugger timing:
  - Write: S_IDLE → S_DBG_ACK. dbg_ack at grant+1.
  - Read: S_IDLE → S_DBG_RD → S_DBG_ACK when the tag exits. dbg_ack at grant+RD_LAT+1, with dbg_rdata valid in the same cycle.
  - S_DBG_ACK → S_IDLE. dbg_busy drops in the ack cycle.
  - dbg_req still high in the cycle after the ack counts as a new request.
- Simultaneous cpu_req and dbg_req with counter < STARVE_MAX and mcu_paused=0: the CPU wins and the counter increments.
- Reset mid-operation: outstanding debugger read discarded, no dbg_ack, tag pipeline flushed.
- No data shifting or masking for byte accesses; mem_byte passes through unchanged.

Optional Feature:
- Macro: DEBUG_MEM_ARB_STALL_CNT_EN.
- Defined: stall_cnt is a 16-bit register that increments each cycle cpu_req & cpu_stall, saturates at 16'hFFFF, and clears on reset.
- Undefined: stall_cnt tied to 0 and no counter is synthesized.

Test Plan:
- cpu_req=0; debugger read addr 0x100, mem returns 0xDEADBEEF, RD_LAT=1 -> mem_en at cycle t; dbg_ack at t+2 with dbg_rdata=0xDEADBEEF; dbg_busy high t+1..t+1.
- cpu_req held 1 continuously; debugger write 0x200 := 0x12345678, STARVE_MAX=15 -> CPU served 15 cycles; debugger granted on the 16th cycle with cpu_stall=1 for exactly that cycle; dbg_ack next cycle; stall_cnt=1 (macro on).
- mcu_paused=1 and cpu_req=1 with dbg_req -> debugger granted immediately, cpu_stall=1.
- Debugger read at t, CPU read at t+1, RD_LAT=2, mem data A then B -> dbg_rdata=A, cpu_rdata=B at t+3, no cross-delivery.
- reset asserted the cycle after a debugger read grant -> no dbg_ack, dbg_busy=0, state S_IDLE; next request is served normally.
- dbg_req left high after ack with cpu_req=0 -> second access issues the cycle after the ack; two dbg_ack pulses total.

Source files
------------

// File: rtl/debug_mem_arbiter.sv
// Purpose: shares one single-port memory between the CPU datapath (priority) and the debug controller.
// Latency: grant is combinational; CPU read data RD_LAT cycles after issue; dbg_ack at grant+1 (write) or grant+RD_LAT+1 (read).
// Backpressure: cpu_stall refuses the CPU only in a debugger grant cycle; the debugger holds dbg_req until dbg_ack.
// Optional: define DEBUG_MEM_ARB_STALL_CNT_EN to build the saturating 16-bit stall_cnt counter.
module debug_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_byte,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              mcu_paused,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              dbg_byte,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_busy,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stall_cnt
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DBG_RD  = 2'd1,
      S_DBG_ACK = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        starve_cnt;
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_dbg;
   logic              dbg_grant;
   logic              rd_issue;
   logic              tag_out_vld;
   logic              tag_out_dbg;

   // The oldest tag stage lines up with the memory's read data for that access.
   assign tag_out_vld = tag_vld[RD_LAT-1];
   assign tag_out_dbg = tag_dbg[RD_LAT-1];
   assign rd_issue    = mem_en & ~mem_we;

   // Debugger wins an idle port, a paused MCU, or once it has been starved long enough.
   always_comb begin
      dbg_grant = 1'b0;
      if (!reset && state == S_IDLE && dbg_req)
         dbg_grant = !cpu_req || mcu_paused || (starve_cnt == STARVE_LIM);
   end

   // Memory port mux: debugger on its grant cycle, otherwise straight CPU pass-through.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_stall = 1'b0;
      if (dbg_grant) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_byte  = dbg_byte;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         cpu_stall = cpu_req;
      end else if (!reset) begin
         mem_en    = cpu_req;
         mem_we    = cpu_req & cpu_we;
         mem_byte  = cpu_req & cpu_byte;
      end
   end

   // Debugger op state register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Debugger op sequencing and its status outputs (quiet while reset is held).
   always_comb begin
      state_nxt = state;
      dbg_busy  = 1'b0;
      dbg_ack   = 1'b0;
      case (state)
         S_IDLE: begin
            if (dbg_grant) state_nxt = dbg_we ? S_DBG_ACK : S_DBG_RD;
         end
         S_DBG_RD: begin
            dbg_busy = !reset;
            if (tag_out_vld && tag_out_dbg) state_nxt = S_DBG_ACK;
         end
         S_DBG_ACK: begin
            dbg_ack   = !reset;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counts refused cycles of a pending debugger request; saturates at the preemption threshold.
   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (dbg_grant)
         starve_cnt <= '0;
      else if (state == S_IDLE && dbg_req && starve_cnt != STARVE_LIM)
         starve_cnt <= starve_cnt + 8'd1;
   end

   // Ownership tags ride alongside each read so returning data reaches the right requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld <= '0;
         tag_dbg <= '0;
      end else begin
         tag_vld[0] <= rd_issue;
         tag_dbg[0] <= dbg_grant;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_dbg[i] <= tag_dbg[i-1];
         end
      end
   end

   // Debugger read data is captured and held until its next read completes.
   always_ff @(posedge clk) begin
      if (reset)
         dbg_rdata <= '0;
      else if (tag_out_vld && tag_out_dbg)
         dbg_rdata <= mem_rdata;
   end

   // CPU read data is forwarded combinationally only when the returning read is the CPU's.
   assign cpu_rdata = (tag_out_vld && !tag_out_dbg) ? mem_rdata : '0;

`ifdef DEBUG_MEM_ARB_STALL_CNT_EN
   // Saturating count of cycles in which the CPU was held off.
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (cpu_req && cpu_stall && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign stall_cnt = '0;
`endif

endmodule
